// File: rtl/bottling_line_ctrl_pkg.sv
// Shared types and defaults for the bottling line sequencer.
package bottling_line_ctrl_pkg;

    localparam int CNT_W_DEFAULT          = 8;
    localparam int BOTTLE_TIMEOUT_DEFAULT = 1000;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_BOTTLE = 3'd1,
        ST_FILL        = 3'd2,
        ST_ADVANCE     = 3'd3,
        ST_DONE        = 3'd4,
        ST_FAULT       = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'b00,
        ERR_TIMEOUT     = 2'b01,
        ERR_BOTTLE_LOST = 2'b10,
        ERR_STRAY_PILL  = 2'b11
    } err_e;

    // States in which a batch is actively being sequenced.
    function automatic logic is_busy_state(input state_e s);
        return (s == ST_WAIT_BOTTLE) || (s == ST_FILL) || (s == ST_ADVANCE);
    endfunction

    // States in which the bottle watchdog runs (waiting on bottle arrive/leave).
    function automatic logic is_timed_state(input state_e s);
        return (s == ST_WAIT_BOTTLE) || (s == ST_ADVANCE);
    endfunction

endpackage

// File: rtl/bottling_line_ctrl_timer.sv
// Bottle watchdog: counts enabled cycles from a clear and flags when the
// count reaches TIMEOUT. The count saturates there so the flag stays up.
module bottling_line_ctrl_timer
    import bottling_line_ctrl_pkg::*;
#(
    parameter int TIMEOUT = BOTTLE_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] count_reg;

    // Cycle counter: clear wins over enable, holds once the limit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != LIMIT)) begin
            count_reg <= count_reg + TW'(1);
        end
    end

    assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/bottling_line_ctrl.sv
// Pill-bottling batch sequencer: holds batch configuration, gates the pill
// feeder, steps the conveyor per bottle, counts pills/bottles and latches the
// first fault seen until the operator clears it.
module bottling_line_ctrl
    import bottling_line_ctrl_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEFAULT,
    parameter int BOTTLE_TIMEOUT = BOTTLE_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_pills,
    input  logic [CNT_W-1:0] cfg_bottles,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             pill_pulse,
    input  logic             bottle_in_place,
    output logic             feed_en,
    output logic             conveyor_step,
    output logic [CNT_W-1:0] pill_count,
    output logic [CNT_W-1:0] bottle_count,
    output logic             busy,
    output logic             done,
    output logic             alarm,
    output logic [1:0]       err_code
);

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] cfg_pills_reg, cfg_bottles_reg;
    logic [CNT_W-1:0] pill_count_reg, pill_count_next;
    logic [CNT_W-1:0] bottle_count_reg, bottle_count_next;
    logic [CNT_W-1:0] pill_count_inc;
    logic [1:0]       err_reg, err_next;
    logic             start_d_reg;
    logic             start_rise;
    logic             cfg_valid;
    logic             timer_clr, timer_en, timer_expired;
    logic             feed_en_reg, feed_en_next;
    logic             step_reg, step_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             alarm_reg, alarm_next;

    assign start_rise     = start && !start_d_reg;
    assign cfg_valid      = (cfg_pills_reg != '0) && (cfg_bottles_reg != '0);
    assign pill_count_inc = pill_count_reg + CNT_W'(1);

    // Remember last start level so only a rising edge launches a batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_d_reg <= 1'b0;
        end else begin
            start_d_reg <= start;
        end
    end

    // Batch configuration is only accepted while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_pills_reg   <= '0;
            cfg_bottles_reg <= '0;
        end else if (cfg_load && (state_reg == ST_IDLE)) begin
            cfg_pills_reg   <= cfg_pills;
            cfg_bottles_reg <= cfg_bottles;
        end
    end

    // Watchdog restarts on every state change and only runs while waiting on a bottle.
    assign timer_clr = clear || (state_next != state_reg);
    assign timer_en  = is_timed_state(state_reg) && !pause;

    bottling_line_ctrl_timer #(
        .TIMEOUT (BOTTLE_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, counters and output decode. Order: clear, faults, pause, normal.
    // When several faults coincide the timeout is reported ahead of the others.
    always_comb begin
        state_next        = state_reg;
        pill_count_next   = pill_count_reg;
        bottle_count_next = bottle_count_reg;
        err_next          = err_reg;

        if (clear) begin
            state_next        = ST_IDLE;
            pill_count_next   = '0;
            bottle_count_next = '0;
            err_next          = ERR_NONE;
        end else begin
            unique case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start_rise && cfg_valid) begin
                        pill_count_next   = '0;
                        bottle_count_next = '0;
                        state_next        = ST_WAIT_BOTTLE;
                    end
                end
                ST_WAIT_BOTTLE: begin
                    if (timer_expired) begin
                        state_next = ST_FAULT;
                        err_next   = ERR_TIMEOUT;
                    end else if (pill_pulse) begin
                        state_next = ST_FAULT;
                        err_next   = ERR_STRAY_PILL;
                    end else if (!pause && bottle_in_place) begin
                        state_next = ST_FILL;
                    end
                end
                ST_FILL: begin
                    // A pill already in flight is counted even while paused.
                    if (!bottle_in_place) begin
                        state_next = ST_FAULT;
                        err_next   = ERR_BOTTLE_LOST;
                    end else if (pill_pulse) begin
                        if (pill_count_inc == cfg_pills_reg) begin
                            pill_count_next = '0;
                            if (bottle_count_reg < cfg_bottles_reg) begin
                                bottle_count_next = bottle_count_reg + CNT_W'(1);
                            end
                            state_next = ST_ADVANCE;
                        end else begin
                            pill_count_next = pill_count_inc;
                        end
                    end
                end
                ST_ADVANCE: begin
                    if (timer_expired) begin
                        state_next = ST_FAULT;
                        err_next   = ERR_TIMEOUT;
                    end else if (pill_pulse) begin
                        state_next = ST_FAULT;
                        err_next   = ERR_STRAY_PILL;
                    end else if (!pause && !bottle_in_place) begin
                        state_next = (bottle_count_reg >= cfg_bottles_reg) ? ST_DONE
                                                                          : ST_WAIT_BOTTLE;
                    end
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        // Step fires only on entry into ADVANCE, so a paused ADVANCE never repeats it.
        feed_en_next = (state_next == ST_FILL) && !pause;
        step_next    = (state_next == ST_ADVANCE) && (state_reg != ST_ADVANCE);
        busy_next    = is_busy_state(state_next);
        done_next    = (state_next == ST_DONE);
        alarm_next   = (state_next == ST_FAULT);
    end

    // Pill/bottle counters and the latched error code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pill_count_reg   <= '0;
            bottle_count_reg <= '0;
            err_reg          <= ERR_NONE;
        end else begin
            pill_count_reg   <= pill_count_next;
            bottle_count_reg <= bottle_count_next;
            err_reg          <= err_next;
        end
    end

    // Registered actuator and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feed_en_reg <= 1'b0;
            step_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            alarm_reg   <= 1'b0;
        end else begin
            feed_en_reg <= feed_en_next;
            step_reg    <= step_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            alarm_reg   <= alarm_next;
        end
    end

    assign feed_en       = feed_en_reg;
    assign conveyor_step = step_reg;
    assign pill_count    = pill_count_reg;
    assign bottle_count  = bottle_count_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign alarm         = alarm_reg;
    assign err_code      = err_reg;

endmodule

// File: tb/tb_bottling_line_ctrl.sv
// Directed bench for bottling_line_ctrl: stimulus queues expected events
// (conveyor step, batch done, alarm); a negedge monitor pops and checks them.
module tb_bottling_line_ctrl;

    localparam int CW  = 8;
    localparam int TMO = 50;

    localparam int EV_STEP  = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ALARM = 2;

    typedef struct {
        int        kind;
        logic [7:0] bc;
        logic [1:0] err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_load;
    logic [CW-1:0] cfg_pills;
    logic [CW-1:0] cfg_bottles;
    logic          start;
    logic          pause;
    logic          clear;
    logic          pill_pulse;
    logic          bottle_in_place;
    logic          feed_en;
    logic          conveyor_step;
    logic [CW-1:0] pill_count;
    logic [CW-1:0] bottle_count;
    logic          busy;
    logic          done;
    logic          alarm;
    logic [1:0]    err_code;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    logic done_prev  = 1'b0;
    logic alarm_prev = 1'b0;

    bottling_line_ctrl #(
        .CNT_W          (CW),
        .BOTTLE_TIMEOUT (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_load        (cfg_load),
        .cfg_pills       (cfg_pills),
        .cfg_bottles     (cfg_bottles),
        .start           (start),
        .pause           (pause),
        .clear           (clear),
        .pill_pulse      (pill_pulse),
        .bottle_in_place (bottle_in_place),
        .feed_en         (feed_en),
        .conveyor_step   (conveyor_step),
        .pill_count      (pill_count),
        .bottle_count    (bottle_count),
        .busy            (busy),
        .done            (done),
        .alarm           (alarm),
        .err_code        (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input logic [7:0] bc, input logic [1:0] err);
        exp_t e;
        e.kind = kind;
        e.bc   = bc;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    // sel: 0 feed_en high, 1 done high
    task automatic wait_until(input int sel, input string name, input int limit);
        int  n   = 0;
        bit  hit = 1'b0;
        while (!hit && n < limit) begin
            hit = (sel == 0) ? feed_en : done;
            if (!hit) begin
                tick();
                n++;
            end
        end
        if (!hit) begin
            checks++;
            $display("FAIL wait_%s: not seen within %0d cycles", name, limit);
        end
    endtask

    task automatic load_cfg(input logic [7:0] p, input logic [7:0] b);
        cfg_pills   = p;
        cfg_bottles = b;
        cfg_load    = 1'b1;
        tick();
        cfg_load    = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic pill();
        pill_pulse = 1'b1;
        tick();
        pill_pulse = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic observe(input int kind);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL sb_unexpected: event %0d seen with none expected", kind);
        end else begin
            e = sb_q.pop_front();
            $display("event kind=%0d bottle_count=%0d err=%0d (expected kind=%0d)",
                     kind, bottle_count, err_code, e.kind);
            chk("sb_kind", kind, e.kind);
            if (e.kind == EV_ALARM) begin
                chk("sb_err_code", err_code, e.err);
                chk("sb_alarm_feed_en", feed_en, 0);
                chk("sb_alarm_busy", busy, 0);
            end else begin
                chk("sb_bottle_count", bottle_count, e.bc);
            end
        end
    endtask

    // Monitor: one transaction per step pulse, done rise or alarm rise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (conveyor_step)         observe(EV_STEP);
            if (done && !done_prev)    observe(EV_DONE);
            if (alarm && !alarm_prev)  observe(EV_ALARM);
        end
        done_prev  = done;
        alarm_prev = alarm;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; cfg_load = 1'b0; cfg_pills = '0; cfg_bottles = '0;
        start = 1'b0; pause = 1'b0; clear = 1'b0; pill_pulse = 1'b0; bottle_in_place = 1'b0;
        tick(); tick();
        chk("reset_outputs", {feed_en, conveyor_step, pill_count, bottle_count,
                              busy, done, alarm, err_code}, 0);
        rst_n = 1'b1;
        tick();

        // 1: 3 pills x 2 bottles, normal run.
        load_cfg(8'd3, 8'd2);
        push_ev(EV_STEP, 8'd1, 2'b00);
        push_ev(EV_STEP, 8'd2, 2'b00);
        push_ev(EV_DONE, 8'd2, 2'b00);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_wait_busy", busy, 1);
        chk("t1_wait_feed_off", feed_en, 0);
        for (int b = 1; b <= 2; b++) begin
            bottle_in_place = 1'b1;
            wait_until(0, "t1_fill", 10);
            for (int p = 1; p <= 3; p++) begin
                pill();
                chk("t1_pill_count", pill_count, (p == 3) ? 0 : p);
                tick();
            end
            chk("t1_adv_feed_off", feed_en, 0);
            bottle_in_place = 1'b0;
            tick();
            tick();
        end
        wait_until(1, "t1_done", 10);
        chk("t1_bottle_count", bottle_count, 2);
        chk("t1_done_busy", busy, 0);

        // 2: no bottle arrives -> timeout.
        do_clear();
        chk("t2_cleared", {done, bottle_count}, 0);
        push_ev(EV_ALARM, 8'd0, 2'b01);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!alarm && n < TMO + 20) begin
            tick();
            n++;
        end
        chk("t2_timeout_cycles", n, TMO + 2);
        chk("t2_err_code", err_code, 2'b01);
        chk("t2_busy", busy, 0);
        do_clear();
        chk("t2_clear_alarm", {alarm, err_code}, 0);

        // 3: bottle removed during fill.
        start_pulse();
        bottle_in_place = 1'b1;
        wait_until(0, "t3_fill", 10);
        pill();
        chk("t3_pill_count", pill_count, 1);
        push_ev(EV_ALARM, 8'd0, 2'b10);
        bottle_in_place = 1'b0;
        tick();
        chk("t3_feed_off", feed_en, 0);
        chk("t3_err_code", err_code, 2'b10);
        do_clear();

        // 4: stray pill while waiting; then stray pill coincident with clear.
        start_pulse();
        push_ev(EV_ALARM, 8'd0, 2'b11);
        pill();
        chk("t4_err_code", err_code, 2'b11);
        do_clear();
        start_pulse();
        pill_pulse = 1'b1;
        clear      = 1'b1;
        tick();
        pill_pulse = 1'b0;
        clear      = 1'b0;
        tick();
        chk("t4_clear_wins", {alarm, busy, err_code}, 0);

        // 5: pause with last pill in flight; ADVANCE frozen past the timeout.
        load_cfg(8'd2, 8'd1);
        start_pulse();
        bottle_in_place = 1'b1;
        wait_until(0, "t5_fill", 10);
        pill();
        tick();
        push_ev(EV_STEP, 8'd1, 2'b00);
        pause = 1'b1;
        pill();
        chk("t5_bottle_count", bottle_count, 1);
        chk("t5_pill_count", pill_count, 0);
        bottle_in_place = 1'b0;
        repeat (TMO + 10) tick();
        chk("t5_frozen", {busy, alarm, done}, 3'b100);
        push_ev(EV_DONE, 8'd1, 2'b00);
        pause = 1'b0;
        tick();
        chk("t5_done", done, 1);

        // 6: zero config ignored; cfg_load during fill ignored.
        do_clear();
        load_cfg(8'd0, 8'd2);
        start_pulse();
        tick();
        chk("t6_zero_cfg_idle", busy, 0);
        load_cfg(8'd2, 8'd1);
        start_pulse();
        bottle_in_place = 1'b1;
        wait_until(0, "t6_fill", 10);
        push_ev(EV_STEP, 8'd1, 2'b00);
        load_cfg(8'd5, 8'd3);
        pill();
        tick();
        pill();
        chk("t6_cfg_kept", {pill_count, bottle_count}, {8'd0, 8'd1});
        tick();
        push_ev(EV_DONE, 8'd1, 2'b00);
        bottle_in_place = 1'b0;
        tick();
        tick();
        chk("t6_done", done, 1);

        // 7: restart from DONE, then async reset mid-fill.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t7_restart", {done, busy}, 2'b01);
        tick();
        bottle_in_place = 1'b1;
        wait_until(0, "t7_fill", 10);
        pill();
        chk("t7_pill_count", pill_count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_async_reset", {feed_en, busy, pill_count}, 0);
        tick();
        rst_n = 1'b1;
        bottle_in_place = 1'b0;
        tick();
        start_pulse();
        tick();
        chk("t7_cfg_reset_idle", busy, 0);

        repeat (3) tick();
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
